// File: rtl/elevator_car_model.sv
// Cycle-level model of an elevator car serving four floors, driven by motor and door commands.
// Illegal-operation detection and the sticky FAULT state are built only with ELEVATOR_CAR_FAULT_EN defined.
module elevator_car_model #(
    parameter int TRAVEL_TICKS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m_up,
    input  logic       m_dn,
    input  logic [3:0] door,
    output logic [1:0] floor,
    output logic       at_floor,
    output logic       arrive,
    output logic       moving,
    output logic       fault
);

    localparam int MAX_POS = 3 * TRAVEL_TICKS;
    localparam int PW      = $clog2(MAX_POS + 1);

    localparam logic [PW-1:0] POS_F1  = PW'(TRAVEL_TICKS);
    localparam logic [PW-1:0] POS_F2  = PW'(2 * TRAVEL_TICKS);
    localparam logic [PW-1:0] POS_MAX = PW'(MAX_POS);

    typedef enum logic [1:0] {
        STOP,
        UP,
        DN,
        FAULT
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] pos;
    logic [PW-1:0] pos_nx;
    logic [1:0]    floor_nx;
    logic          at_floor_nx;
    logic          arrive_nx;
    logic          moving_nx;
    logic          fault_nx;
    logic          up_req;
    logic          dn_req;
    logic          illegal;

`ifdef ELEVATOR_CAR_FAULT_EN
    logic both_req;
    logic overrun;
    logic door_bad;

    // Door checks use the registered view of the car, i.e. what the controller saw.
    always_comb begin
        both_req = m_up & m_dn;
        overrun  = (up_req && (pos == POS_MAX)) || (dn_req && (pos == '0));
        door_bad = ((|door) && (!at_floor || moving)) ||
                   (|(door & ~(4'b0001 << floor)));
        illegal  = both_req | overrun | door_bad;
    end
`else
    logic unused_door;

    assign unused_door = ^door;
    assign illegal     = 1'b0;
`endif

    assign up_req = m_up & ~m_dn;
    assign dn_req = m_dn & ~m_up;

    always_comb begin
        state_nx = state;
        pos_nx   = pos;
        if (state == FAULT) begin
            state_nx = FAULT;
        end else if (illegal) begin
            state_nx = FAULT;
        end else if (up_req) begin
            state_nx = UP;
            if (pos != POS_MAX) begin
                pos_nx = pos + PW'(1);
            end
        end else if (dn_req) begin
            state_nx = DN;
            if (pos != '0) begin
                pos_nx = pos - PW'(1);
            end
        end else begin
            state_nx = STOP;
        end
    end

    // Output values are derived from the next position so they appear registered with it.
    always_comb begin
        floor_nx = 2'd0;
        if (pos_nx >= POS_MAX) begin
            floor_nx = 2'd3;
        end else if (pos_nx >= POS_F2) begin
            floor_nx = 2'd2;
        end else if (pos_nx >= POS_F1) begin
            floor_nx = 2'd1;
        end
        at_floor_nx = (pos_nx == '0) || (pos_nx == POS_F1) ||
                      (pos_nx == POS_F2) || (pos_nx == POS_MAX);
        arrive_nx   = at_floor_nx && !at_floor;
        moving_nx   = (pos_nx != pos);
`ifdef ELEVATOR_CAR_FAULT_EN
        fault_nx    = (state_nx == FAULT);
`else
        fault_nx    = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= STOP;
            pos      <= '0;
            floor    <= 2'd0;
            at_floor <= 1'b1;
            arrive   <= 1'b0;
            moving   <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= state_nx;
            pos      <= pos_nx;
            floor    <= floor_nx;
            at_floor <= at_floor_nx;
            arrive   <= arrive_nx;
            moving   <= moving_nx;
            fault    <= fault_nx;
        end
    end

endmodule

// File: doc/elevator_car_model.md
ELEVATOR_CAR_MODEL -- requirements
Module: elevator_car_model

Interface
REQ-001 The block SHALL have parameter TRAVEL_TICKS, default 16, giving clock cycles of motor drive per floor-to-floor move; legal range is 2..1024.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port m_up, input, 1 bit: motor-up command from the elevator controller.
REQ-005 The block SHALL have port m_dn, input, 1 bit: motor-down command from the elevator controller.
REQ-006 The block SHALL have port door, input, 4 bits: door-open command, one bit per floor, bit 0 = floor 0.
REQ-007 The block SHALL have port floor, output, 2 bits: current floor when aligned, else last floor passed.
REQ-008 The block SHALL have port at_floor, output, 1 bit: car exactly aligned with a floor.
REQ-009 The block SHALL have port arrive, output, 1 bit: one-cycle pulse on becoming aligned with a floor.
REQ-010 The block SHALL have port moving, output, 1 bit: car moved on the last edge.
REQ-011 The block SHALL have port fault, output, 1 bit: sticky illegal-operation flag.

Function
REQ-012 Car position SHALL be an unsigned counter pos in 0..3*TRAVEL_TICKS; floor = pos / TRAVEL_TICKS, saturating at 3; at_floor = (pos mod TRAVEL_TICKS == 0).
REQ-013 The state machine SHALL have states STOP, UP, DN and FAULT; all outputs SHALL be registered.
REQ-014 Each edge, m_up=1 and m_dn=0 SHALL select UP and increment pos by 1; m_dn=1 and m_up=0 SHALL select DN and decrement pos by 1; both 0 SHALL select STOP and hold pos.
REQ-015 Stopping between floors SHALL hold pos, leave at_floor=0, and resume from the same pos; reversing mid-travel SHALL be legal and move back toward the previous floor.
REQ-016 arrive SHALL pulse for exactly one cycle on the edge where pos reaches a multiple of TRAVEL_TICKS from a non-multiple, both when passing through a floor and when stopping at it.
REQ-017 moving SHALL be 1 on every cycle in which pos changed on the preceding edge.
REQ-018 At pos = 3*TRAVEL_TICKS, m_up SHALL be an overrun and pos SHALL saturate; at pos = 0, m_dn SHALL be an overrun and pos SHALL saturate.
REQ-019 Illegal conditions SHALL be: (a) m_up and m_dn both 1; (b) overrun per REQ-018; (c) any door bit 1 while at_floor=0 or moving=1; (d) any door bit other than bit[floor] equal to 1.
REQ-020 Entering FAULT SHALL freeze pos; FAULT SHALL be left only by reset.

Reset
REQ-021 Asserting rst_n low SHALL immediately force state=STOP, pos=0, floor=0, at_floor=1, arrive=0, moving=0, fault=0, regardless of any operation in progress.
REQ-022 The first edge after rst_n deasserts SHALL evaluate inputs normally, with no extra delay.

Configuration
REQ-023 With macro ELEVATOR_CAR_FAULT_EN defined, REQ-019 and REQ-020 SHALL apply and fault SHALL go to 1 on the edge that samples the illegal condition and stay at 1.
REQ-024 Without ELEVATOR_CAR_FAULT_EN, fault SHALL be tied to 0 and FAULT SHALL be unreachable; condition (a) SHALL be treated as STOP, overrun SHALL only saturate, and door checks SHALL be ignored.

Verification
REQ-025 The bench SHALL run each scenario below with TRAVEL_TICKS=4 and ELEVATOR_CAR_FAULT_EN defined unless stated otherwise.
REQ-026 Reset, then m_up held 4 cycles -> pos=4, floor=1, at_floor=1, arrive high exactly on the 4th edge, moving=1 on cycles 1..4.
REQ-027 m_up held 12 cycles from reset -> arrive pulses at pos 4, 8 and 12; a 13th m_up cycle -> pos stays 12 and fault=1.
REQ-028 m_up 2 cycles, idle 3 cycles, m_dn 2 cycles -> pos 2, then held at 2 with at_floor=0, then back to 0 with arrive once and fault=0.
REQ-029 At floor 1 stopped, door=4'b0010 -> fault stays 0; door=4'b0100 -> fault=1 on the next edge and pos frozen.
REQ-030 m_up=m_dn=1 for one cycle -> fault=1; the same stimulus without ELEVATOR_CAR_FAULT_EN -> pos unchanged and fault=0.
REQ-031 rst_n pulsed low mid-travel at pos=6 -> all outputs return to reset values asynchronously, before the next clock edge.
